instr_encoder: RTL

Encodes ALU micro-ops into 32-bit RV32I instruction words and streams them into instruction memory. It covers the same eight-instruction subset the CPU control decoder recognises: ADDI, XORI, ORI, ANDI, ADD, XOR, OR, AND. It sits between the test/program-generation logic and the instruction-memory write port, and is the program loader for the single-cycle CPU. Field encoding matches the decoder's `alu_op`/`is_r_type` convention, so encode→decode round-trips.

---
 rtl/instr_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
// Turns ALU micro-ops (ADDI/XORI/ORI/ANDI/ADD/XOR/OR/AND) into RV32I words
// and writes them, one per cycle, into instruction memory starting at
// BASE_ADDR after a start pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begins a load session (honoured only when idle)
//   in_valid/in_ready   micro-op handshake (ready only while running)
//   in_alu_op           001 add, 100 xor, 110 or, 111 and
//   in_is_r_type        1: rs2 operand, 0: imm12 operand
//   in_rd/rs1/rs2/imm12 instruction fields
//   in_last             final micro-op of the session
//   mem_we/addr/wdata   registered instruction-memory write port
//   busy, done, err     status: not idle, end pulse, sticky unsupported op
//   word_cnt            words written in the current or last session
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | accepting micro-ops
// DONE   | one-cycle end-of-session pulse
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_alu_op,
  input  logic              in_is_r_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm12,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              op_ok;
  logic [2:0]        funct3;
  logic [31:0]       enc_word;

  always_comb begin
    op_ok = 1'b0;
    case (in_alu_op)
      3'b001, 3'b100, 3'b110, 3'b111: op_ok = 1'b1;
      default:                        op_ok = 1'b0;
    endcase
  end

  // add is the only op whose funct3 differs from its alu_op code
  assign funct3 = (in_alu_op == 3'b001) ? 3'b000 : in_alu_op;

  always_comb begin
    if (in_is_r_type)
      enc_word = {7'b0000000, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
    else
      enc_word = {in_imm12, in_rs1, funct3, in_rd, 7'b0010011};
  end

  assign accept   = in_valid && (state == S_RUN);
  assign in_ready = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        // a full memory ends the session even without in_last
        if (accept && (in_last || (op_ok && word_cnt == LAST_SLOT)))
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept && op_ok;
      if (state == S_IDLE && start) begin
        wr_ptr   <= ADDR_W'(BASE_ADDR);
        word_cnt <= '0;
        err      <= 1'b0;
      end
      if (accept) begin
        if (op_ok) begin
          mem_addr  <= wr_ptr;
          mem_wdata <= enc_word;
          wr_ptr    <= wr_ptr + 1'b1;
          word_cnt  <= word_cnt + 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
